// File: rtl/transmit_result.sv
// -----------------------------------------------------------------------------
// transmit_result
//
// UART transmitter for the calculator's result path. It takes an 8-nibble
// result word on a one-cycle send request, drops leading zero nibbles, and
// sends each remaining nibble as an ASCII hex character on txd. Framing is
// 8N1 at a fixed baud of clk / BAUD_DIV. Bytes follow each other back-to-back
// with no idle gap.
//
// Build option:
//   TX_CRLF_EN - when defined, 0x0D then 0x0A follow the last digit byte
//                before the sequence completes.
//
// Parameters:
//   BAUD_DIV   - clock cycles per UART bit (>= 2)
//   NUM_DIGITS - nibbles in the digits word (fixed at 8)
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   send   in   one-cycle request, sampled only while idle
//   digits in   [31:28] most significant nibble .. [3:0] least significant
//   busy   out  high from the cycle after an accepted send until completion
//   done   out  one-cycle pulse after the final stop bit
//   txd    out  registered serial output, idle high
// -----------------------------------------------------------------------------
module transmit_result #(
   parameter int BAUD_DIV   = 5208,
   parameter int NUM_DIGITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        send,
   input  logic [31:0] digits,
   output logic        busy,
   output logic        done,
   output logic        txd
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t          state_r;
   logic [31:0]     word_r;
   logic [2:0]      ptr_r;
   logic [2:0]      bit_r;
   logic [CW-1:0]   baud_r;
   logic [7:0]      tx_byte_s;
   logic            baud_end_s;
`ifdef TX_CRLF_EN
   // 0 = digit bytes, 1 = carriage return, 2 = line feed
   logic [1:0]      tail_r;
`endif

   // Hex nibble to ASCII: 0-9 -> '0'-'9', A-F -> 'A'-'F'
   function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
      logic [7:0] c;
      if (n < 4'd10) begin
         c = {4'h3, n};
      end else begin
         c = {4'h4, n - 4'd9};
      end
      return c;
   endfunction

   // Index of the most significant non-zero nibble; 0 when the word is zero
   function automatic logic [2:0] first_digit(input logic [31:0] w);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w[i*4 +: 4] != 4'd0) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Byte currently being framed, selected from the latched word (or CR/LF)
   always_comb begin
      tx_byte_s = nibble_ascii(word_r[{ptr_r, 2'b00} +: 4]);
`ifdef TX_CRLF_EN
      case (tail_r)
         2'd1:    tx_byte_s = 8'h0D;
         2'd2:    tx_byte_s = 8'h0A;
         default: tx_byte_s = nibble_ascii(word_r[{ptr_r, 2'b00} +: 4]);
      endcase
`endif
   end

   assign baud_end_s = (baud_r == BAUD_LAST);

   // Transmit FSM; txd, busy and done are all updated here so they stay registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         word_r  <= 32'd0;
         ptr_r   <= 3'd0;
         bit_r   <= 3'd0;
         baud_r  <= CW'(0);
         busy    <= 1'b0;
         done    <= 1'b0;
         txd     <= 1'b1;
`ifdef TX_CRLF_EN
         tail_r  <= 2'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               txd  <= 1'b1;
               if (send) begin
                  word_r  <= digits;
                  ptr_r   <= first_digit(digits);
                  bit_r   <= 3'd0;
                  baud_r  <= CW'(0);
                  busy    <= 1'b1;
                  txd     <= 1'b0;   // start bit begins on the accepting edge
                  state_r <= START;
`ifdef TX_CRLF_EN
                  tail_r  <= 2'd0;
`endif
               end else begin
                  busy <= 1'b0;
               end
            end

            START: begin
               if (baud_end_s) begin
                  baud_r  <= CW'(0);
                  txd     <= tx_byte_s[0];
                  state_r <= DATA;
               end else begin
                  baud_r <= baud_r + CW'(1);
               end
            end

            DATA: begin
               if (baud_end_s) begin
                  baud_r <= CW'(0);
                  if (bit_r == 3'd7) begin
                     bit_r   <= 3'd0;
                     txd     <= 1'b1;
                     state_r <= STOP;
                  end else begin
                     bit_r <= bit_r + 3'd1;
                     txd   <= tx_byte_s[bit_r + 3'd1];
                  end
               end else begin
                  baud_r <= baud_r + CW'(1);
               end
            end

            STOP: begin
               if (baud_end_s) begin
                  baud_r <= CW'(0);
                  if (ptr_r != 3'd0) begin
                     // more digits: next start bit immediately, no idle gap
                     ptr_r   <= ptr_r - 3'd1;
                     txd     <= 1'b0;
                     state_r <= START;
`ifdef TX_CRLF_EN
                  end else if (tail_r != 2'd2) begin
                     tail_r  <= tail_r + 2'd1;
                     txd     <= 1'b0;
                     state_r <= START;
`endif
                  end else begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     txd     <= 1'b1;
                     state_r <= DONE;
                  end
               end else begin
                  baud_r <= baud_r + CW'(1);
               end
            end

            DONE: begin
               // send is deliberately ignored in this cycle
               busy    <= 1'b0;
               done    <= 1'b0;
               txd     <= 1'b1;
               state_r <= IDLE;
            end

            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               txd     <= 1'b1;
               baud_r  <= CW'(0);
               bit_r   <= 3'd0;
               ptr_r   <= 3'd0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
